// File: rtl/sd_pipe2p_mem.sv
// rtl/sd_pipe2p_mem.sv - two-port memory with byte lanes, clearing sweep and 1-3 cycle read pipeline
module sd_pipe2p_mem #(
    parameter int                width      = 32,
    parameter int                depth      = 256,
    parameter int                addr_sz    = $clog2(depth),
    parameter int                gran       = 8,
    parameter int                rd_latency = 1,
    parameter bit                wr_first   = 1'b0,
    parameter logic [width-1:0]  init_val   = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [width/gran-1:0]    wr_be,
    input  logic [addr_sz-1:0]       wr_addr,
    input  logic [width-1:0]         d_in,
    input  logic                     rd_en,
    input  logic [addr_sz-1:0]       rd_addr,
    output logic [width-1:0]         d_out,
    output logic                     rd_valid,
    output logic                     init_done
);

    localparam int                 NLANES    = width / gran;
    localparam logic [addr_sz-1:0] LAST_ADDR = addr_sz'(depth - 1);
    localparam logic [addr_sz:0]   DEPTH_X   = (addr_sz + 1)'(depth);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [addr_sz-1:0]     r_cnt;
    logic                   w_sweep_last;
    logic [width-1:0]       r_mem [depth];

    logic                   w_wr_ok;
    logic                   w_rd_ok;
    logic                   w_collide;
    logic [width-1:0]       w_rd_word;
    logic [width-1:0]       w_rd_data;

    logic [rd_latency-1:0]  r_vld;
    logic [width-1:0]       r_dat [rd_latency];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) begin
                r_cnt <= w_sweep_last ? '0 : r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sweep_last = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (r_cnt == LAST_ADDR) begin
                    w_sweep_last = 1'b1;
                    w_state_nxt  = ST_READY;
                end
            end
            ST_READY: w_state_nxt = ST_READY;
            default:  w_state_nxt = ST_INIT;
        endcase
    end

    assign init_done = (r_state == ST_READY);

    // Both ports are gated off until the sweep completes; out-of-range writes drop silently.
    assign w_wr_ok   = (r_state == ST_READY) && wr_en && ({1'b0, wr_addr} < DEPTH_X);
    assign w_rd_ok   = (r_state == ST_READY) && rd_en;
    assign w_collide = w_wr_ok && (rd_addr == wr_addr);
    assign w_rd_word = r_mem[rd_addr];

    always_comb begin
        w_rd_data = w_rd_word;
        if (wr_first && w_collide) begin
            for (int i = 0; i < NLANES; i++) begin
                if (wr_be[i]) begin
                    w_rd_data[i*gran +: gran] = d_in[i*gran +: gran];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_cnt] <= init_val;
        end else if (w_wr_ok) begin
            for (int i = 0; i < NLANES; i++) begin
                if (wr_be[i]) begin
                    r_mem[wr_addr][i*gran +: gran] <= d_in[i*gran +: gran];
                end
            end
        end
    end

    // Data stages only advance with their valid bit, so d_out holds between reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld <= '0;
            for (int k = 0; k < rd_latency; k++) begin
                r_dat[k] <= '0;
            end
        end else begin
            r_vld[0] <= w_rd_ok;
            if (w_rd_ok) begin
                r_dat[0] <= w_rd_data;
            end
            for (int k = 1; k < rd_latency; k++) begin
                r_vld[k] <= r_vld[k-1];
                if (r_vld[k-1]) begin
                    r_dat[k] <= r_dat[k-1];
                end
            end
        end
    end

    assign d_out    = r_dat[rd_latency-1];
    assign rd_valid = r_vld[rd_latency-1];

endmodule

// File: tb/tb_sd_pipe2p_mem.sv
// tb/tb_sd_pipe2p_mem.sv - scoreboard bench driving three differently configured memories in lockstep
module tb_sd_pipe2p_mem;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_be = '0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] d_in = '0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_addr = '0;

    logic [31:0] do_a, do_b, do_c;
    logic        rv_a, rv_b, rv_c;
    logic        id_a, id_b, id_c;

    always #5 clk = ~clk;

    // a: depth 16, latency 3, read-old. b: depth 16, latency 1, write-first. c: depth 12, latency 2, write-first.
    sd_pipe2p_mem #(.width(32), .depth(16), .gran(8), .rd_latency(3), .wr_first(1'b0),
                    .init_val(32'hA5A5A5A5)) u_a (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr),
        .d_in(d_in), .rd_en(rd_en), .rd_addr(rd_addr), .d_out(do_a), .rd_valid(rv_a),
        .init_done(id_a));

    sd_pipe2p_mem #(.width(32), .depth(16), .gran(8), .rd_latency(1), .wr_first(1'b1),
                    .init_val(32'hA5A5A5A5)) u_b (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr),
        .d_in(d_in), .rd_en(rd_en), .rd_addr(rd_addr), .d_out(do_b), .rd_valid(rv_b),
        .init_done(id_b));

    sd_pipe2p_mem #(.width(32), .depth(12), .gran(8), .rd_latency(2), .wr_first(1'b1),
                    .init_val(32'h0)) u_c (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr),
        .d_in(d_in), .rd_en(rd_en), .rd_addr(rd_addr), .d_out(do_c), .rd_valid(rv_c),
        .init_done(id_c));

    typedef struct {
        logic [31:0] d;
        bit          chk;
        int          cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input logic [31:0] d, input bit c, input int cy);
        exp_t e;
        e.d   = d;
        e.chk = c;
        e.cyc = cy;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic cmp_rd(input string nm, input exp_t e, input logic [31:0] got);
        n_vec++;
        if (e.cyc != cyc || (e.chk && got !== e.d)) begin
            n_err++;
            $display("FAIL rd_%s: got %h at cycle %0d, expected %h (checked=%0d) at cycle %0d",
                     nm, got, cyc, e.d, e.chk, e.cyc);
        end
    endtask

    task automatic unexpected(input string nm, input logic [31:0] got);
        n_vec++;
        n_err++;
        $display("FAIL rd_%s: unexpected rd_valid with data %h at cycle %0d, expected no read", nm, got, cyc);
    endtask

    always @(negedge clk) begin : mon_a
        if (rv_a) begin
            if (q_a.size() == 0) unexpected("a", do_a);
            else cmp_rd("a", q_a.pop_front(), do_a);
        end
    end

    always @(negedge clk) begin : mon_b
        if (rv_b) begin
            if (q_b.size() == 0) unexpected("b", do_b);
            else cmp_rd("b", q_b.pop_front(), do_b);
        end
    end

    always @(negedge clk) begin : mon_c
        if (rv_c) begin
            if (q_c.size() == 0) unexpected("c", do_c);
            else cmp_rd("c", q_c.pop_front(), do_c);
        end
    end

    task automatic op(input bit we, input logic [3:0] be, input logic [3:0] wa, input logic [31:0] di,
                      input bit re, input logic [3:0] ra,
                      input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ec, input bit cc);
        @(negedge clk);
        #1;
        wr_en   = we;
        wr_be   = be;
        wr_addr = wa;
        d_in    = di;
        rd_en   = re;
        rd_addr = ra;
        if (re) begin
            q_a.push_back(mk(ea, 1'b1, cyc + 3));
            q_b.push_back(mk(eb, 1'b1, cyc + 1));
            q_c.push_back(mk(ec, cc, cyc + 2));
        end
    endtask

    task automatic wr(input logic [3:0] wa, input logic [3:0] be, input logic [31:0] di);
        op(1'b1, be, wa, di, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic rd(input logic [3:0] ra, input logic [31:0] ea, input logic [31:0] eb,
                      input logic [31:0] ec, input bit cc);
        op(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, ra, ea, eb, ec, cc);
    endtask

    task automatic idle();
        op(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic drain();
        int n;
        idle();
        n = 0;
        while ((q_a.size() + q_b.size() + q_c.size()) != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if ((q_a.size() + q_b.size() + q_c.size()) != 0) begin
            n_err++;
            $display("FAIL drain: %0d/%0d/%0d reads outstanding after 30 cycles, expected 0/0/0",
                     q_a.size(), q_b.size(), q_c.size());
            q_a.delete();
            q_b.delete();
            q_c.delete();
        end
    endtask

    task automatic rst();
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        q_a.delete();
        q_b.delete();
        q_c.delete();
        #1;
        chk("rst_rv_a", {31'b0, rv_a}, 32'd0);
        chk("rst_rv_b", {31'b0, rv_b}, 32'd0);
        chk("rst_rv_c", {31'b0, rv_c}, 32'd0);
        chk("rst_id_a", {31'b0, id_a}, 32'd0);
        chk("rst_id_b", {31'b0, id_b}, 32'd0);
        chk("rst_id_c", {31'b0, id_c}, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Releases reset and follows the sweep for n edges; reads/writes poked mid-sweep must be ignored.
    task automatic sweep(input int n, input bit pokes);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            chk($sformatf("init_done_a_e%0d", k), {31'b0, id_a}, (k >= 16) ? 32'd1 : 32'd0);
            chk($sformatf("init_done_b_e%0d", k), {31'b0, id_b}, (k >= 16) ? 32'd1 : 32'd0);
            chk($sformatf("init_done_c_e%0d", k), {31'b0, id_c}, (k >= 12) ? 32'd1 : 32'd0);
            if (pokes) begin
                rd_en   = (k == 3 || k == 11);
                rd_addr = 4'd2;
                wr_en   = (k == 5);
                wr_addr = 4'd3;
                wr_be   = 4'hF;
                d_in    = 32'hFFFFFFFF;
            end
        end
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    function automatic logic [31:0] mval(input int a, input logic [31:0] iv);
        case (a)
            0:       return 32'h10101010;
            1:       return 32'hDEADBEEF;
            2:       return 32'h30303030;
            3:       return 32'h11BB33DD;
            5:       return 32'h0000FFFF;
            default: return iv;
        endcase
    endfunction

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded 100000 time units");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_do_a", do_a, 32'h0);
        chk("reset_do_b", do_b, 32'h0);
        chk("reset_do_c", do_c, 32'h0);
        chk("reset_rv_a", {31'b0, rv_a}, 32'd0);
        chk("reset_rv_b", {31'b0, rv_b}, 32'd0);
        chk("reset_rv_c", {31'b0, rv_c}, 32'd0);

        sweep(6, 1'b0);
        rst();
        sweep(16, 1'b1);

        for (int a = 0; a < 16; a++) begin
            rd(4'(a), 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, a < 12);
        end
        drain();

        wr(4'd3, 4'hF, 32'h11223344);
        wr(4'd3, 4'h5, 32'hAABBCCDD);
        rd(4'd3, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 1'b1);
        wr(4'd3, 4'h0, 32'hFFFFFFFF);
        rd(4'd3, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 1'b1);

        wr(4'd5, 4'hF, 32'h0);
        op(1'b1, 4'hF, 4'd5, 32'hFFFFFFFF, 1'b1, 4'd5, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        rd(4'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        wr(4'd5, 4'hF, 32'h0);
        op(1'b1, 4'h3, 4'd5, 32'hFFFFFFFF, 1'b1, 4'd5, 32'h0, 32'h0000FFFF, 32'h0000FFFF, 1'b1);
        rd(4'd5, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF, 1'b1);
        drain();

        wr(4'd0, 4'hF, 32'h10101010);
        wr(4'd1, 4'hF, 32'h20202020);
        wr(4'd2, 4'hF, 32'h30303030);
        rd(4'd0, 32'h10101010, 32'h10101010, 32'h10101010, 1'b1);
        rd(4'd1, 32'h20202020, 32'h20202020, 32'h20202020, 1'b1);
        rd(4'd2, 32'h30303030, 32'h30303030, 32'h30303030, 1'b1);
        rd(4'd1, 32'h20202020, 32'h20202020, 32'h20202020, 1'b1);
        wr(4'd1, 4'hF, 32'hDEADBEEF);
        rd(4'd1, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
        drain();
        repeat (3) @(negedge clk);
        chk("hold_do_a", do_a, 32'hDEADBEEF);
        chk("hold_do_b", do_b, 32'hDEADBEEF);
        chk("hold_do_c", do_c, 32'hDEADBEEF);

        wr(4'd13, 4'hF, 32'h12345678);
        rd(4'd13, 32'h12345678, 32'h12345678, 32'h0, 1'b0);
        for (int a = 0; a < 12; a++) begin
            rd(4'(a), mval(a, 32'hA5A5A5A5), mval(a, 32'hA5A5A5A5), mval(a, 32'h0), 1'b1);
        end
        drain();

        rd(4'd3, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 1'b1);
        rd(4'd4, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, 1'b1);
        rst();
        sweep(16, 1'b1);
        for (int a = 0; a < 6; a++) begin
            rd(4'(a), 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, 1'b1);
        end
        drain();
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sd_pipe2p_mem.md
# sd_pipe2p_mem

Single-clock, parametrised two-port (one write, one read) behavioural memory; successor to the team's basic two-port memory. Adds byte-lane write enables, configurable read latency (1–3 cycles) with a read-valid strobe, selectable read-during-write collision behaviour, and a post-reset clearing sweep. Sits under FIFOs, reorder buffers and lookup tables that need deterministic contents after reset and a fixed, known read latency.

## Interface
- width, 32: data word width in bits; must be a multiple of gran.
- depth, 256: number of words; need not be a power of two.
- addr_sz, $clog2(depth): address width.
- gran, 8: bits per write-enable lane; nlanes = width/gran.
- rd_latency, 1: cycles from rd_en to d_out/rd_valid; legal values 1, 2, 3.
- wr_first, 0: collision mode; 0 = read-old, 1 = write-first (forward new data).
- init_val, 0: width-bit value written to every word by the clearing sweep.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  write strobe.
- wr_be  input  nlanes  per-lane write enable; lane i covers bits [i*gran +: gran].
- wr_addr  input  addr_sz  write address.
- d_in  input  width  write data.
- rd_en  input  1  read strobe.
- rd_addr  input  addr_sz  read address.
- d_out  output  width  read data, valid while rd_valid = 1.
- rd_valid  output  1  one-cycle strobe per accepted read.
- init_done  output  1  1 once the clearing sweep has finished.

## Operation
- FSM states: INIT, READY.
- Reset (reset_n = 0): state = INIT, sweep counter = 0, all read-pipeline valid bits = 0, d_out = 0, rd_valid = 0, init_done = 0. Array contents are not reset directly.
- INIT: each cycle, write init_val to word[counter] and increment the counter. After writing word depth-1, go to READY and set init_done = 1. The sweep takes exactly depth cycles. wr_en and rd_en are ignored; ignored reads produce no rd_valid.
- READY: init_done stays 1. The FSM never returns to INIT except through reset.
- Write: when wr_en = 1 and wr_addr < depth, update only lanes with wr_be[i] = 1. wr_be = 0 is a no-op. Out-of-range addresses are dropped with no side effects.
- Read: when rd_en = 1, stage 1 captures word[rd_addr] plus a valid bit. Stages 2..rd_latency are plain delay registers. d_out and rd_valid come from the last stage.
  - An out-of-range read still produces rd_valid; d_out is then undefined.
- d_out holds its last value when rd_valid = 0. It is not cleared.
- Collision (rd_en and wr_en in the same cycle, rd_addr == wr_addr):
  - wr_first = 0: the read returns the pre-write word.
  - wr_first = 1: the read returns the merged word. Each enabled lane carries d_in; each other lane carries the old data.
  - The array is updated in both modes.
- Only same-cycle collisions are handled. A write landing after the read's capture cycle never alters that in-flight read.
- Back-to-back reads are accepted every cycle; throughput is 1 read and 1 write per cycle.

## Timing
- rd_en sampled at edge N → d_out/rd_valid valid in the cycle after edge N+rd_latency-1. For rd_latency = 1, output appears the cycle after the request.
- A write at edge N is visible to a non-colliding read issued at edge N+1 or later.
- reset_n assertion takes effect immediately (asynchronous). Deassertion is assumed synchronised externally; the first INIT write occurs at the first rising edge with reset_n = 1.
- Reset asserted mid-sweep or mid-read: the sweep restarts from 0 and in-flight reads are discarded (no rd_valid).
- init_done rises at the edge that writes word depth-1, i.e. it is high from the cycle after sweep edge depth.

## Test plan
- Sweep: depth = 16, init_val = 'hA5A5A5A5. Release reset → init_done rises after exactly 16 edges. Reading addresses 0..15 returns 'hA5A5A5A5. rd_en pulsed during INIT → no rd_valid.
- Byte lanes: write 'h11223344 to address 3 with wr_be = 4'b1111, then 'hAABBCCDD with wr_be = 4'b0101. Read address 3 → 'h11BB33DD.
- Collision: address 5 holds 'h0, then a same-cycle write of 'hFFFF_FFFF (all lanes) and read of address 5. wr_first = 0 → 'h0. wr_first = 1 → 'hFFFF_FFFF. Partial wr_be = 4'b0011 with wr_first = 1 → 'h0000_FFFF. A later read returns the array value in every case.
- Latency: rd_latency = 3, reads of addresses 0,1,2 on consecutive cycles. rd_valid is high on the 3rd, 4th and 5th cycles after the first request, with data in order. Repeat with rd_latency = 1 and 2.
- Reset mid-operation: assert reset_n = 0 at sweep count 7 and again with two reads in flight. rd_valid and init_done drop immediately. After release the sweep restarts and completes in depth cycles. The discarded reads never appear.
- Range: depth = 12, write to address 13 → no array change. Read of address 13 → rd_valid asserted, data ignored. Reads of addresses 0..11 unaffected.
